// File: rtl/acum_pkg.sv
`default_nettype none
// ---- acum_pkg: op codes and width helpers for acum_canal_sat (rev 1.0) ----
package acum_pkg;

  typedef enum logic [1:0] {
    OP_ACC  = 2'b00,
    OP_CLR  = 2'b01,
    OP_HOLD = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  function automatic int acc_width(input int n, input int gb);
    return 2 * n + gb;
  endfunction

  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/redondeo_sat.sv
`default_nettype none
// ---- redondeo_sat: round-half-up, arithmetic shift and clip to N bits (rev 1.0) ----
module redondeo_sat #(
  parameter int AW   = 53,
  parameter int N    = 25,
  parameter int FRAC = 10
) (
  input  logic signed [AW-1:0] sum,
  output logic signed [N-1:0]  y,
  output logic                 sat
);

  localparam logic signed [AW:0] MAXV = {{(AW+2-N){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW+2-N){1'b1}}, {(N-1){1'b0}}};

  logic signed [AW:0] half;
  logic signed [AW:0] biased;
  logic signed [AW:0] shifted;
  logic               hi;
  logic               lo;

  if (FRAC > 0) begin : g_half
    assign half = {{AW{1'b0}}, 1'b1} << (FRAC - 1);
  end else begin : g_nohalf
    assign half = '0;
  end

  // One extra bit so adding the rounding constant can never wrap.
  assign biased  = {sum[AW-1], sum} + half;
  assign shifted = biased >>> FRAC;
  assign hi      = shifted > MAXV;
  assign lo      = shifted < MINV;
  assign sat     = hi | lo;
  assign y       = hi ? MAXV[N-1:0] : (lo ? MINV[N-1:0] : shifted[N-1:0]);

endmodule
`default_nettype wire

// File: rtl/acum_canal_sat.sv
`default_nettype none
// ---- acum_canal_sat: multi-channel TAPS-product accumulator with rounding/saturation (rev 1.0) ----
module acum_canal_sat
  import acum_pkg::*;
#(
  parameter int N    = 25,
  parameter int CH   = 2,
  parameter int TAPS = 5,
  parameter int FRAC = 10,
  parameter int GB   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [1:0]                 op,
  input  logic [ch_width(CH)-1:0]    ch_sel,
  input  logic signed [2*N-1:0]      prod,
  output logic signed [N-1:0]        y,
  output logic                       y_valid,
  output logic [ch_width(CH)-1:0]    y_ch,
  output logic                       sat,
  output logic [CH-1:0]              ovf,
  output logic                       err
);

  localparam int AW   = acc_width(N, GB);
  localparam int CW   = ch_width(CH);
  localparam int CNTW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(TAPS - 1);

  logic signed [AW-1:0] acc_q [CH];
  logic signed [AW-1:0] acc_d [CH];
  logic [CNTW-1:0]      cnt_q [CH];
  logic [CNTW-1:0]      cnt_d [CH];
  logic [CH-1:0]        ovf_q, ovf_d;

  logic signed [N-1:0]  y_q;
  logic [CW-1:0]        y_ch_q;
  logic                 y_valid_q, sat_q, err_q;

  logic                 ch_ok, emit, rnd_sat;
  logic [CW-1:0]        sel;
  logic signed [AW-1:0] prod_ext, sum, emit_sum;
  logic signed [N-1:0]  rnd_y;

  assign ch_ok    = 32'(ch_sel) < 32'(CH);
  assign sel      = ch_ok ? ch_sel : '0;
  assign prod_ext = AW'(prod);
  assign sum      = acc_q[sel] + prod_ext;
  // LOAD only emits when TAPS==1; then the result is the product itself.
  assign emit_sum = (op == OP_LOAD) ? prod_ext : sum;

  redondeo_sat #(.AW(AW), .N(N), .FRAC(FRAC)) u_rnd (
    .sum (emit_sum),
    .y   (rnd_y),
    .sat (rnd_sat)
  );

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    emit  = 1'b0;
    if (in_valid && ch_ok) begin
      case (op_e'(op))
        OP_ACC: begin
          if (cnt_q[sel] == LAST) begin
            emit       = 1'b1;
            acc_d[sel] = '0;
            cnt_d[sel] = '0;
          end else begin
            acc_d[sel] = sum;
            cnt_d[sel] = cnt_q[sel] + 1'b1;
          end
        end
        OP_CLR: begin
          acc_d[sel] = '0;
          cnt_d[sel] = '0;
          ovf_d[sel] = 1'b0;
        end
        OP_LOAD: begin
          if (TAPS == 1) begin
            emit = 1'b1;
          end else begin
            acc_d[sel] = prod_ext;
            cnt_d[sel] = CNTW'(1);
          end
        end
        OP_HOLD: ;
      endcase
      if (emit && rnd_sat) ovf_d[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      ovf_q     <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      y_valid_q <= emit;
      sat_q     <= emit & rnd_sat;
      err_q     <= in_valid & ~ch_ok;
      if (emit) begin
        y_q    <= rnd_y;
        y_ch_q <= sel;
      end
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign sat     = sat_q;
  assign err     = err_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_acum_canal_sat.sv
`default_nettype none
// ---- tb_acum_canal_sat: vector table, corner sequences and random run against a reference model (rev 1.0) ----
`timescale 1ns/1ps
module tb_acum_canal_sat;
  import acum_pkg::*;

  localparam int N = 25, CH = 2, TAPS = 5, FRAC = 10, GB = 3;
  localparam longint P1   = 1048576;
  localparam longint BIG  = longint'(1) << 46;
  localparam longint YMAX = (longint'(1) << (N - 1)) - 1;
  localparam longint YMIN = -(longint'(1) << (N - 1));

  logic clk = 1'b0;
  logic reset;
  logic in_valid; logic [1:0] op; logic [0:0] ch_sel; logic signed [49:0] prod;
  logic signed [24:0] y; logic y_valid; logic [0:0] y_ch; logic sat; logic [1:0] ovf; logic err;

  logic in_valid3; logic [1:0] op3; logic [1:0] ch_sel3; logic signed [49:0] prod3;
  logic signed [24:0] y3; logic y_valid3; logic [1:0] y_ch3; logic sat3; logic [2:0] ovf3; logic err3;

  always #5 clk = ~clk;

  acum_canal_sat #(.N(N), .CH(CH), .TAPS(TAPS), .FRAC(FRAC), .GB(GB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .ch_sel(ch_sel), .prod(prod),
    .y(y), .y_valid(y_valid), .y_ch(y_ch), .sat(sat), .ovf(ovf), .err(err));

  acum_canal_sat #(.N(N), .CH(3), .TAPS(TAPS), .FRAC(FRAC), .GB(GB)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .op(op3), .ch_sel(ch_sel3), .prod(prod3),
    .y(y3), .y_valid(y_valid3), .y_ch(y_ch3), .sat(sat3), .ovf(ovf3), .err(err3));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-channel running sum and beat count.
  longint m_acc [CH];
  int     m_cnt [CH];
  bit     m_ovf [CH];
  bit     m_yv, m_sat, m_err;
  longint m_y;
  int     m_ych;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin m_acc[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; end
    m_yv = 0; m_sat = 0; m_err = 0; m_y = 0; m_ych = 0;
  endfunction

  function automatic void model_beat(input bit v, input logic [1:0] o, input int ch, input longint p);
    longint s, r;
    bit emit;
    m_yv = 0; m_sat = 0; m_err = 0; emit = 0; s = 0;
    if (!v) return;
    if (ch >= CH) begin m_err = 1; return; end
    case (o)
      2'b00: begin
        s = m_acc[ch] + p;
        m_cnt[ch]++;
        if (m_cnt[ch] == TAPS) begin emit = 1; m_acc[ch] = 0; m_cnt[ch] = 0; end
        else m_acc[ch] = s;
      end
      2'b01: begin m_acc[ch] = 0; m_cnt[ch] = 0; m_ovf[ch] = 0; end
      2'b11: begin m_acc[ch] = p; m_cnt[ch] = 1; end
      default: ;
    endcase
    if (emit) begin
      r = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
      m_yv = 1; m_ych = ch; m_sat = 0;
      if (r > YMAX) begin r = YMAX; m_sat = 1; end
      if (r < YMIN) begin r = YMIN; m_sat = 1; end
      m_y = r;
      if (m_sat) m_ovf[ch] = 1;
    end
  endfunction

  task automatic drive(input bit v, input logic [1:0] o, input int ch, input longint p);
    in_valid = v; op = o; ch_sel = ch[0:0]; prod = p[49:0];
    @(posedge clk); #1;
    model_beat(v, o, ch, p);
  endtask

  task automatic drive3(input bit v, input logic [1:0] o, input int ch, input longint p);
    in_valid3 = v; op3 = o; ch_sel3 = ch[1:0]; prod3 = p[49:0];
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " y_valid"}, y_valid, m_yv);
    check({tag, " err"}, err, m_err);
    check({tag, " ovf"}, ovf, {m_ovf[1], m_ovf[0]});
    if (m_yv) begin
      check({tag, " y"}, y, m_y);
      check({tag, " y_ch"}, y_ch, m_ych);
      check({tag, " sat"}, sat, m_sat);
    end
  endtask

  typedef struct {
    bit v; logic [1:0] op; int ch; longint p;
    bit yv; longint y; int ych;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input bit v, input logic [1:0] o, input int ch, input longint p,
                     input bit yv, input longint yy, input int ych);
    vec_t r;
    r = '{v, o, ch, p, yv, yy, ych};
    tbl.push_back(r);
  endtask

  initial begin
    // Five ACC beats on ch0 with HOLD beats and idle gaps in between.
    add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_HOLD, 0, 999, 0, 0, 0);
    add(0, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(0, OP_LOAD, 0, P1, 0, 0, 0);
    add(1, OP_HOLD, 1, 777, 0, 0, 0);
    add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_ACC, 0, P1, 1, 5120, 0);
    add(0, OP_ACC, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(1, OP_ACC, i % 2, (i % 2) ? -1024 : 1024, i >= 8, (i % 2) ? -5 : 5, i % 2);
    add(0, OP_ACC, 0, 0, 0, 0, 0);
    add(1, OP_LOAD, 1, 512, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, OP_ACC, 1, 0, 0, 0, 0);
    add(1, OP_ACC, 1, 0, 1, 1, 1);
    add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_LOAD, 0, P1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, OP_ACC, 0, P1, 0, 0, 0);
    add(1, OP_ACC, 0, P1, 1, 5120, 0);
    add(1, OP_ACC, 1, P1, 0, 0, 0);
    add(1, OP_CLR, 1, P1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, OP_ACC, 1, P1, 0, 0, 0);
    add(1, OP_ACC, 1, P1, 1, 5120, 1);
    add(1, OP_LOAD, 0, -513, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, OP_ACC, 0, 0, 0, 0, 0);
    add(1, OP_ACC, 0, 0, 1, -1, 0);
    add(0, OP_ACC, 0, 0, 0, 0, 0);

    reset = 1'b0;
    in_valid = 0; op = 0; ch_sel = 0; prod = 0;
    in_valid3 = 0; op3 = 0; ch_sel3 = 0; prod3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset y", y, 0);
    check("reset y_valid", y_valid, 0);
    check("reset y_ch", y_ch, 0);
    check("reset sat", sat, 0);
    check("reset ovf", ovf, 0);
    check("reset err", err, 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].ch, tbl[i].p);
      check($sformatf("tbl%0d y_valid", i), y_valid, tbl[i].yv);
      check($sformatf("tbl%0d err", i), err, 0);
      if (tbl[i].yv) begin
        check($sformatf("tbl%0d y", i), y, tbl[i].y);
        check($sformatf("tbl%0d y_ch", i), y_ch, tbl[i].ych);
        check($sformatf("tbl%0d sat", i), sat, 0);
      end
    end

    // Positive and negative saturation, sticky ovf, CLR clears only its channel.
    for (int i = 0; i < 5; i++) drive(1, OP_ACC, 0, BIG);
    check("satp y_valid", y_valid, 1);
    check("satp y", y, YMAX);
    check("satp sat", sat, 1);
    check("satp ovf", ovf, 2'b01);
    drive(0, OP_ACC, 0, 0);
    check("satp idle sat", sat, 0);
    check("satp idle ovf", ovf, 2'b01);
    drive(1, OP_CLR, 0, BIG);
    check("clr ovf", ovf, 2'b00);
    for (int i = 0; i < 5; i++) drive(1, OP_ACC, 1, -BIG);
    check("satn y", y, YMIN);
    check("satn sat", sat, 1);
    check("satn ovf", ovf, 2'b10);

    // Asynchronous reset mid-accumulation, right while a result is on the output.
    for (int i = 0; i < 4; i++) drive(1, OP_ACC, 1, P1);
    for (int i = 0; i < 3; i++) drive(1, OP_ACC, 0, P1);
    drive(1, OP_ACC, 1, P1);
    check("pre-rst y_valid", y_valid, 1);
    check("pre-rst y", y, 5120);
    check("pre-rst y_ch", y_ch, 1);
    in_valid = 0;
    #1 reset = 1'b0;
    #1;
    check("async rst y", y, 0);
    check("async rst y_valid", y_valid, 0);
    check("async rst y_ch", y_ch, 0);
    check("async rst ovf", ovf, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, OP_ACC, 0, P1);
      check($sformatf("post-rst ch0 beat%0d y_valid", i), y_valid, i == 4);
    end
    check("post-rst ch0 y", y, 5120);
    for (int i = 0; i < 5; i++) begin
      drive(1, OP_ACC, 1, P1);
      check($sformatf("post-rst ch1 beat%0d y_valid", i), y_valid, i == 4);
    end
    check("post-rst ch1 y", y, 5120);
    drive(0, OP_ACC, 0, 0);

    // Out-of-range channel on a three-channel instance.
    drive3(1, OP_LOAD, 1, 512);
    drive3(1, OP_ACC, 1, 0);
    drive3(1, OP_ACC, 3, BIG);
    check("err pulse", err3, 1);
    check("err y_valid", y_valid3, 0);
    drive3(0, OP_ACC, 3, BIG);
    check("err idle", err3, 0);
    drive3(1, OP_ACC, 1, 0);
    drive3(1, OP_ACC, 1, 0);
    check("err clears", err3, 0);
    drive3(1, OP_ACC, 1, 0);
    check("err seq y_valid", y_valid3, 1);
    check("err seq y", y3, 1);
    check("err seq y_ch", y_ch3, 1);
    check("err seq ovf", ovf3, 0);
    drive3(0, OP_ACC, 0, 0);

    // Randomized beats against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit v;
      logic [1:0] o;
      int ch, r;
      longint p;
      logic [63:0] raw;
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      o = (r < 13) ? 2'b00 : (r == 13) ? 2'b01 : (r < 16) ? 2'b10 : 2'b11;
      ch = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: p = longint'($urandom_range(0, 2 * 1048576)) - P1;
        1: begin raw = {$urandom, $urandom}; p = $signed(raw[49:0]); end
        2: p = ($urandom_range(0, 1) != 0) ? 512 : -512;
        default: p = ($urandom_range(0, 1) != 0) ? BIG : -BIG;
      endcase
      drive(v, o, ch, p);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
